// File: rtl/systick_counter_if.sv
// Avalon-MM register bus bundle for the systick counter.
// The 16-bit data path and 3-bit address match the rest of the peripheral set.
interface systick_counter_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/systick_counter.sv
// Free-running 32-bit uptime counter advanced by rising edges of the interval timer irq,
// with a 32-bit alarm compare raising its own interrupt.
module systick_counter #(
   parameter logic [31:0] COUNT_INIT = 32'h0000_0000,
   parameter logic [31:0] ALARM_INIT = 32'hFFFF_FFFF
) (
   input  logic             clk,
   input  logic             reset,
   systick_counter_if.slave bus,
   input  logic             tick_in,
   output logic             irq
);

   logic [31:0] count_r;
   logic [31:0] alarm_r;
   logic [15:0] pend_l_r;
   logic [15:0] shadow_h_r;
   logic [15:0] readdata_r;
   logic        ie_r;
   logic        run_r;
   logic        alarm_hit_r;
   logic        ovf_r;
   logic        tick_d_r;

   logic [7:0]  wr_s;
   logic        rd_l_s;
   logic        tick_ev_s;
   logic        clr_s;
   logic        load_s;
   logic        inc_s;
   logic        alarm_set_s;
   logic        ovf_set_s;
   logic [31:0] count_inc_s;
   logic [31:0] count_nxt_s;
   logic [15:0] rd_mux_s;

   // Bus strobe decode and count/flag next-state selection.
   always_comb begin
      wr_s        = 8'd0;
      rd_l_s      = 1'b0;
      if (bus.chipselect && !bus.write_n) begin
         wr_s[bus.address] = 1'b1;
      end else begin
         wr_s = 8'd0;
      end
      if (bus.chipselect && !bus.read_n && (bus.address == 3'd2)) begin
         rd_l_s = 1'b1;
      end else begin
         rd_l_s = 1'b0;
      end

      tick_ev_s   = tick_in & ~tick_d_r;
      clr_s       = wr_s[1] & bus.writedata[2];
      load_s      = wr_s[3];
      // A tick that collides with a clear or a load is dropped, never deferred.
      inc_s       = run_r & tick_ev_s & ~clr_s & ~load_s;
      count_inc_s = count_r + 32'd1;
      ovf_set_s   = inc_s & (count_r == 32'hFFFF_FFFF);
      alarm_set_s = inc_s & (count_inc_s == alarm_r);

      if (clr_s) begin
         count_nxt_s = 32'd0;
      end else if (load_s) begin
         count_nxt_s = {bus.writedata, pend_l_r};
      end else if (inc_s) begin
         count_nxt_s = count_inc_s;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Read-data address mux, sampled every clock regardless of chipselect.
   always_comb begin
      rd_mux_s = 16'd0;
      case (bus.address)
         3'd0:    rd_mux_s = {13'd0, run_r, ovf_r, alarm_hit_r};
         3'd1:    rd_mux_s = {14'd0, run_r, ie_r};
         3'd2:    rd_mux_s = count_r[15:0];
         3'd3:    rd_mux_s = shadow_h_r;
         3'd4:    rd_mux_s = alarm_r[15:0];
         3'd5:    rd_mux_s = alarm_r[31:16];
         default: rd_mux_s = 16'd0;
      endcase
   end

   // Register file, counter, flags, and registered read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r     <= COUNT_INIT;
         alarm_r     <= ALARM_INIT;
         pend_l_r    <= 16'd0;
         shadow_h_r  <= 16'd0;
         readdata_r  <= 16'd0;
         ie_r        <= 1'b0;
         run_r       <= 1'b0;
         alarm_hit_r <= 1'b0;
         ovf_r       <= 1'b0;
         tick_d_r    <= 1'b0;
      end else begin
         tick_d_r   <= tick_in;
         count_r    <= count_nxt_s;
         readdata_r <= rd_mux_s;
         if (rd_l_s) begin
            shadow_h_r <= count_r[31:16];
         end
         if (wr_s[1]) begin
            ie_r  <= bus.writedata[0];
            run_r <= bus.writedata[1];
         end
         if (wr_s[2]) begin
            pend_l_r <= bus.writedata;
         end
         if (wr_s[4]) begin
            alarm_r[15:0] <= bus.writedata;
         end
         if (wr_s[5]) begin
            alarm_r[31:16] <= bus.writedata;
         end
         // A new match or wrap in the same cycle as a STATUS write keeps the flag set.
         alarm_hit_r <= alarm_set_s | (alarm_hit_r & ~wr_s[0]);
         ovf_r       <= ovf_set_s | (ovf_r & ~wr_s[0]);
      end
   end

   assign bus.readdata = readdata_r;
   assign irq          = alarm_hit_r & ie_r;

endmodule

// File: tb/tb_systick_counter.sv
// Self-checking bench for systick_counter: directed vector table, hand-written
// reset sequence, and randomized traffic against a behavioural model.
module tb_systick_counter;

   logic clk;
   logic reset;
   logic tick_in;
   logic irq;

   systick_counter_if bus ();

   systick_counter dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .tick_in (tick_in),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  a;
      logic        cs;
      logic        rn;
      logic        wn;
      logic [15:0] wd;
      logic        t;
      logic [15:0] erd;
      logic        eirq;
   } vec_t;

   vec_t tbl[$];

   // behavioural model state
   logic [31:0] m_count, m_alarm;
   logic [15:0] m_pend, m_shadow, m_rd;
   logic        m_ie, m_run, m_hit, m_ovf, m_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count = 32'h0000_0000; m_alarm = 32'hFFFF_FFFF;
      m_pend = 16'h0; m_shadow = 16'h0; m_rd = 16'h0;
      m_ie = 1'b0; m_run = 1'b0; m_hit = 1'b0; m_ovf = 1'b0; m_prev = 1'b0;
   endtask

   function automatic logic [15:0] m_view(input logic [2:0] a);
      case (a)
         3'd0:    return {13'd0, m_run, m_ovf, m_hit};
         3'd1:    return {14'd0, m_run, m_ie};
         3'd2:    return m_count[15:0];
         3'd3:    return m_shadow;
         3'd4:    return m_alarm[15:0];
         3'd5:    return m_alarm[31:16];
         default: return 16'h0000;
      endcase
   endfunction

   // One clock of the register-level behaviour, using the state before the edge.
   task automatic model_step(input logic [2:0] a, input logic cs, input logic rn,
                             input logic wn, input logic [15:0] wd, input logic t);
      logic        wr, rdq, rising, clr, load, counts, hit_new, ovf_new;
      logic [32:0] sum;
      wr      = cs && !wn;
      rdq     = cs && !rn;
      rising  = t && !m_prev;
      m_rd    = m_view(a);
      sum     = {1'b0, m_count} + 33'd1;
      clr     = wr && (a == 3'd1) && wd[2];
      load    = wr && (a == 3'd3);
      counts  = m_run && rising && !clr && !load;
      hit_new = counts && (sum[31:0] == m_alarm);
      ovf_new = counts && sum[32];
      if (rdq && a == 3'd2) m_shadow = m_count[31:16];
      if (wr && a == 3'd0) begin
         m_hit = 1'b0;
         m_ovf = 1'b0;
      end
      m_hit = m_hit | hit_new;
      m_ovf = m_ovf | ovf_new;
      if (clr)         m_count = 32'h0;
      else if (load)   m_count = {wd, m_pend};
      else if (counts) m_count = sum[31:0];
      if (wr) begin
         case (a)
            3'd1: begin m_ie = wd[0]; m_run = wd[1]; end
            3'd2: m_pend = wd;
            3'd4: m_alarm[15:0] = wd;
            3'd5: m_alarm[31:16] = wd;
            default: ;
         endcase
      end
      m_prev = t;
   endtask

   task automatic step(input logic [2:0] a, input logic cs, input logic rn,
                       input logic wn, input logic [15:0] wd, input logic t);
      bus.address = a; bus.chipselect = cs; bus.read_n = rn;
      bus.write_n = wn; bus.writedata = wd; tick_in = t;
      @(posedge clk);
      model_step(a, cs, rn, wn, wd, t);
      #1;
      check("model_readdata", {16'h0, bus.readdata}, {16'h0, m_rd});
      check("model_irq", {31'h0, irq}, {31'h0, (m_hit & m_ie)});
      @(negedge clk);
   endtask

   task automatic add(input logic [2:0] a, input logic cs, input logic rn, input logic wn,
                      input logic [15:0] wd, input logic t, input logic [15:0] erd, input logic eirq);
      vec_t v;
      v.a = a; v.cs = cs; v.rn = rn; v.wn = wn; v.wd = wd; v.t = t; v.erd = erd; v.eirq = eirq;
      tbl.push_back(v);
   endtask

   task automatic rd(input logic [2:0] a, input logic [15:0] erd, input logic eirq);
      add(a, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0, erd, eirq);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] wd, input logic t,
                     input logic [15:0] erd, input logic eirq);
      add(a, 1'b1, 1'b1, 1'b0, wd, t, erd, eirq);
   endtask

   task automatic idle(input logic t, input logic eirq);
      add(3'd6, 1'b0, 1'b1, 1'b1, 16'h0, t, 16'h0000, eirq);
   endtask

   initial begin
      logic [15:0] exp_rst [8];
      logic [15:0] wd;
      exp_rst = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0};

      reset = 1'b1; tick_in = 1'b0;
      bus.address = 3'd0; bus.chipselect = 1'b0; bus.read_n = 1'b1;
      bus.write_n = 1'b1; bus.writedata = 16'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_readdata", {16'h0, bus.readdata}, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;

      // reset readback of every address
      for (int i = 0; i < 8; i++) rd(3'(i), exp_rst[i], 1'b0);
      // run, 5 single pulses plus one held level -> 6
      wr(3'd1, 16'h0002, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 5; i++) begin idle(1'b1, 1'b0); idle(1'b0, 1'b0); end
      for (int i = 0; i < 10; i++) idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      rd(3'd2, 16'h0006, 1'b0);
      rd(3'd3, 16'h0000, 1'b0);
      // wrap through FFFFFFFF with default alarm
      wr(3'd2, 16'hFFFE, 1'b0, 16'h0006, 1'b0);
      wr(3'd3, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
      wr(3'd1, 16'h0003, 1'b0, 16'h0002, 1'b0);
      idle(1'b1, 1'b1); idle(1'b0, 1'b1);
      idle(1'b1, 1'b1); idle(1'b0, 1'b1);
      idle(1'b1, 1'b1); idle(1'b0, 1'b1);
      rd(3'd2, 16'h0001, 1'b1);
      rd(3'd3, 16'h0000, 1'b1);
      rd(3'd0, 16'h0007, 1'b1);
      wr(3'd0, 16'h0000, 1'b0, 16'h0007, 1'b0);
      rd(3'd0, 16'h0004, 1'b0);
      // alarm match coincident with STATUS write: set wins
      wr(3'd4, 16'h0010, 1'b0, 16'hFFFF, 1'b0);
      wr(3'd5, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
      wr(3'd2, 16'h000F, 1'b0, 16'h0001, 1'b0);
      wr(3'd3, 16'h0000, 1'b0, 16'h0000, 1'b0);
      wr(3'd0, 16'h0000, 1'b1, 16'h0004, 1'b1);
      rd(3'd0, 16'h0005, 1'b1);
      wr(3'd0, 16'h0000, 1'b0, 16'h0005, 1'b0);
      rd(3'd2, 16'h0010, 1'b0);
      // coherent COUNT_L / COUNT_H across an intervening tick
      wr(3'd2, 16'hFFFF, 1'b0, 16'h0010, 1'b0);
      wr(3'd3, 16'h0001, 1'b0, 16'h0000, 1'b0);
      rd(3'd2, 16'hFFFF, 1'b0);
      idle(1'b1, 1'b0);
      rd(3'd3, 16'h0001, 1'b0);
      rd(3'd2, 16'h0000, 1'b0);
      rd(3'd3, 16'h0002, 1'b0);
      // clear strobe beats a tick that would otherwise hit the alarm
      wr(3'd2, 16'h000F, 1'b0, 16'h0000, 1'b0);
      wr(3'd3, 16'h0000, 1'b0, 16'h0002, 1'b0);
      wr(3'd1, 16'h0007, 1'b1, 16'h0003, 1'b0);
      idle(1'b0, 1'b0);
      rd(3'd2, 16'h0000, 1'b0);
      rd(3'd3, 16'h0000, 1'b0);
      rd(3'd0, 16'h0004, 1'b0);

      foreach (tbl[i]) begin
         step(tbl[i].a, tbl[i].cs, tbl[i].rn, tbl[i].wn, tbl[i].wd, tbl[i].t);
         check($sformatf("vec%0d_readdata", i), {16'h0, bus.readdata}, {16'h0, tbl[i].erd});
         check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].eirq});
      end

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [2:0] a;
         logic cs, rn, wn;
         int op;
         a  = 3'($urandom_range(0, 7));
         cs = ($urandom_range(0, 3) != 0);
         op = $urandom_range(0, 2);
         rn = (op != 0);
         wn = (op != 1);
         case ($urandom_range(0, 4))
            0:       wd = 16'h0000;
            1:       wd = 16'hFFFF;
            2:       wd = 16'h0003;
            3:       wd = 16'hFFFE;
            default: wd = 16'($urandom);
         endcase
         step(a, cs, rn, wn, wd, ($urandom_range(0, 2) == 0));
      end

      // mid-operation reset with irq and readdata both nonzero beforehand
      step(3'd4, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
      step(3'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      step(3'd2, 1'b1, 1'b1, 1'b0, 16'h1233, 1'b0);
      step(3'd3, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      step(3'd1, 1'b1, 1'b1, 1'b0, 16'h0003, 1'b0);
      step(3'd6, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
      step(3'd4, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
      check("pre_reset_irq", {31'h0, irq}, 32'h1);
      check("pre_reset_readdata", {16'h0, bus.readdata}, 32'h1234);
      bus.address = 3'd1; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      bus.writedata = 16'h0003; tick_in = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("async_reset_readdata", {16'h0, bus.readdata}, 32'h0);
      check("async_reset_irq", {31'h0, irq}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(3'd6, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      step(3'd6, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(3'(i), 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
         check($sformatf("post_reset_addr%0d", i), {16'h0, bus.readdata}, {16'h0, exp_rst[i]});
      end
      check("post_reset_irq", {31'h0, irq}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
